semaforo_monitor: RTL and testbench

SEMAFORO_MONITOR -- requirements
Module: semaforo_monitor

---
 rtl/semaforo_pkg.sv | 36 +++
 rtl/contador_fase.sv | 36 +++
 rtl/semaforo_monitor.sv | 132 +++++++++++++
 tb/tb_semaforo_monitor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - shared encodings and defaults for the traffic-light sequence monitor
package semaforo_pkg;

    typedef enum logic [1:0] {
        FASE_ROJO     = 2'd0,
        FASE_VERDE    = 2'd1,
        FASE_AMARILLO = 2'd2,
        FASE_NINGUNA  = 2'd3
    } fase_e;

    localparam logic [1:0] ST_SYNC     = 2'd0;
    localparam logic [1:0] ST_ROJO     = 2'd1;
    localparam logic [1:0] ST_VERDE    = 2'd2;
    localparam logic [1:0] ST_AMARILLO = 2'd3;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_ILEGAL = 3'd1;
    localparam logic [2:0] ERR_ORDEN  = 3'd2;
    localparam logic [2:0] ERR_CORTO  = 3'd3;
    localparam logic [2:0] ERR_LARGO  = 3'd4;

    localparam int DEF_ROJO_TICS     = 35;
    localparam int DEF_VERDE_TICS    = 20;
    localparam int DEF_AMARILLO_TICS = 3;

    // Anything other than exactly one lit lamp is not a phase.
    function automatic fase_e decode_fase(input logic r, input logic v, input logic a);
        case ({r, v, a})
            3'b100:  return FASE_ROJO;
            3'b010:  return FASE_VERDE;
            3'b001:  return FASE_AMARILLO;
            default: return FASE_NINGUNA;
        endcase
    endfunction

endpackage

// File: rtl/contador_fase.sv
// rtl/contador_fase.sv - phase length counter: clear-to-1, saturating increment, limit compare
module contador_fase #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             at_limit_o,
    output logic             below_limit_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o    = (cnt_q == limit_i);
    assign below_limit_o = (cnt_q < limit_i);

endmodule

// File: rtl/semaforo_monitor.sv
// rtl/semaforo_monitor.sv - checks lamp samples against the rojo/verde/amarillo sequence and timing
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter int ROJO_TICS     = DEF_ROJO_TICS,
    parameter int VERDE_TICS    = DEF_VERDE_TICS,
    parameter int AMARILLO_TICS = DEF_AMARILLO_TICS,
    parameter int CNT_W         = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rojo,
    input  logic        amarillo,
    input  logic        verde,
    output logic [1:0]  fase,
    output logic        sync,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [15:0] ciclos
);

    localparam logic [CNT_W-1:0] LIM_ROJO     = CNT_W'(ROJO_TICS);
    localparam logic [CNT_W-1:0] LIM_VERDE    = CNT_W'(VERDE_TICS);
    localparam logic [CNT_W-1:0] LIM_AMARILLO = CNT_W'(AMARILLO_TICS);

    logic             s_rojo_q, s_amarillo_q, s_verde_q;
    logic             prev_rojo_q;
    logic [1:0]       state_q, state_d;
    logic             err_valid_q;
    logic [2:0]       err_code_q, err_d;
    logic [15:0]      ciclos_q, ciclos_d;
    fase_e            s_fase, own_fase, succ_fase;
    logic [1:0]       succ_state;
    logic [CNT_W-1:0] limit;
    logic             cnt_clr, cnt_inc, at_limit, below_limit;

    assign s_fase = decode_fase(s_rojo_q, s_verde_q, s_amarillo_q);

    always_comb begin
        own_fase   = FASE_NINGUNA;
        succ_fase  = FASE_NINGUNA;
        succ_state = ST_SYNC;
        limit      = LIM_ROJO;
        case (state_q)
            ST_ROJO: begin
                own_fase = FASE_ROJO; succ_fase = FASE_VERDE;
                succ_state = ST_VERDE; limit = LIM_ROJO;
            end
            ST_VERDE: begin
                own_fase = FASE_VERDE; succ_fase = FASE_AMARILLO;
                succ_state = ST_AMARILLO; limit = LIM_VERDE;
            end
            ST_AMARILLO: begin
                own_fase = FASE_AMARILLO; succ_fase = FASE_ROJO;
                succ_state = ST_ROJO; limit = LIM_AMARILLO;
            end
            default: ;
        endcase
    end

    // Error causes are mutually exclusive per sample, so branch order encodes the priority.
    always_comb begin
        state_d  = state_q;
        err_d    = ERR_NONE;
        ciclos_d = ciclos_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        if (state_q == ST_SYNC) begin
            if ((s_fase == FASE_ROJO) && !prev_rojo_q) begin
                state_d = ST_ROJO;
                cnt_clr = 1'b1;
            end
        end else if (s_fase == FASE_NINGUNA) begin
            err_d = ERR_ILEGAL;
        end else if (s_fase == own_fase) begin
            if (at_limit) err_d = ERR_LARGO;
            else          cnt_inc = 1'b1;
        end else if (s_fase != succ_fase) begin
            err_d = ERR_ORDEN;
        end else if (below_limit) begin
            err_d = ERR_CORTO;
        end else begin
            state_d = succ_state;
            cnt_clr = 1'b1;
            if ((state_q == ST_AMARILLO) && (ciclos_q != 16'hFFFF)) begin
                ciclos_d = ciclos_q + 16'd1;
            end
        end
        if (err_d != ERR_NONE) state_d = ST_SYNC;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_rojo_q     <= 1'b0;
            s_amarillo_q <= 1'b0;
            s_verde_q    <= 1'b0;
            prev_rojo_q  <= 1'b0;
            state_q      <= ST_SYNC;
            err_valid_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            ciclos_q     <= 16'd0;
        end else begin
            s_rojo_q     <= rojo;
            s_amarillo_q <= amarillo;
            s_verde_q    <= verde;
            prev_rojo_q  <= (s_fase == FASE_ROJO);
            state_q      <= state_d;
            err_valid_q  <= (err_d != ERR_NONE);
            err_code_q   <= err_d;
            ciclos_q     <= ciclos_d;
        end
    end

    contador_fase #(
        .CNT_W(CNT_W)
    ) u_contador (
        .clock        (clock),
        .reset        (reset),
        .clr_i        (cnt_clr),
        .inc_i        (cnt_inc),
        .limit_i      (limit),
        .at_limit_o   (at_limit),
        .below_limit_o(below_limit)
    );

    assign fase      = s_fase;
    assign sync      = (state_q != ST_SYNC);
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign ciclos    = ciclos_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// tb/tb_semaforo_monitor.sv - scoreboard bench for semaforo_monitor
module tb_semaforo_monitor;

    localparam int R = 35;
    localparam int V = 20;
    localparam int A = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rojo = 1'b0, amarillo = 1'b0, verde = 1'b0;
    logic [1:0]  fase;
    logic        sync, err_valid;
    logic [2:0]  err_code;
    logic [15:0] ciclos;

    typedef struct packed {
        logic [15:0] idx;
        logic        ev;
        logic [2:0]  code;
        logic        sy;
    } rec_t;

    rec_t exp_q[$];
    rec_t act_q[$];
    rec_t ea, aa;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_sample = 0;
    bit   pend = 1'b0;

    semaforo_monitor #(
        .ROJO_TICS(R), .VERDE_TICS(V), .AMARILLO_TICS(A), .CNT_W(8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rojo     (rojo),
        .amarillo (amarillo),
        .verde    (verde),
        .fase     (fase),
        .sync     (sync),
        .err_valid(err_valid),
        .err_code (err_code),
        .ciclos   (ciclos)
    );

    always #5 clock = ~clock;

    // Each sample's verdict appears one edge after the edge that captures it.
    task automatic put(input logic r, input logic a, input logic v,
                       input logic ev, input logic [2:0] code, input logic sy);
        rec_t e;
        rojo = r; amarillo = a; verde = v;
        e.idx = 16'(n_sample); e.ev = ev; e.code = code; e.sy = sy;
        exp_q.push_back(e);
        n_sample++;
        @(posedge clock); #1;
        if (pend) act_q.push_back('{16'd0, err_valid, err_code, sync});
        pend = 1'b1;
    endtask

    task automatic run_ok(input logic r, input logic a, input logic v, input int n);
        for (int i = 0; i < n; i++) put(r, a, v, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; rojo = 1'b0; amarillo = 1'b0; verde = 1'b1;
        @(posedge clock); #1;
        n_total += 5;
        if (fase !== 2'd3) $display("FAIL reset_fase got=%0d want=3", fase); else n_pass++;
        if (sync !== 1'b0) $display("FAIL reset_sync got=%b want=0", sync); else n_pass++;
        if (err_valid !== 1'b0) $display("FAIL reset_err_valid got=%b want=0", err_valid); else n_pass++;
        if (err_code !== 3'd0) $display("FAIL reset_err_code got=%0d want=0", err_code); else n_pass++;
        if (ciclos !== 16'd0) $display("FAIL reset_ciclos got=%0d want=0", ciclos); else n_pass++;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete(); act_q.delete(); pend = 1'b0;
    endtask

    task automatic test_nominal();
        put(0, 0, 0, 1'b0, 3'd0, 1'b0);
        put(1, 0, 0, 1'b0, 3'd0, 1'b1);
        run_ok(1, 0, 0, R - 1);
        for (int c = 0; c < 3; c++) begin
            run_ok(0, 0, 1, V);
            run_ok(0, 1, 0, A);
            run_ok(1, 0, 0, (c < 2) ? R : 1);
        end
        put(1, 0, 0, 1'b0, 3'd0, 1'b1);
        n_total++;
        if (ciclos !== 16'd3) $display("FAIL nominal_ciclos got=%0d want=3", ciclos); else n_pass++;
        while (act_q.size() > 0) begin
            ea = exp_q.pop_front(); aa = act_q.pop_front(); n_total++;
            if (aa.ev !== ea.ev || aa.sy !== ea.sy || (ea.ev && aa.code !== ea.code))
                $display("FAIL nominal sample %0d got ev=%b code=%0d sync=%b want ev=%b code=%0d sync=%b",
                         ea.idx, aa.ev, aa.code, aa.sy, ea.ev, ea.code, ea.sy);
            else n_pass++;
        end
    endtask

    task automatic test_short_green();
        run_ok(1, 0, 0, R - 2);
        run_ok(0, 0, 1, V - 1);
        put(0, 1, 0, 1'b1, 3'd3, 1'b0);
        put(0, 0, 0, 1'b0, 3'd0, 1'b0);
        n_total++;
        if (ciclos !== 16'd3) $display("FAIL short_ciclos_hold got=%0d want=3", ciclos); else n_pass++;
        while (act_q.size() > 0) begin
            ea = exp_q.pop_front(); aa = act_q.pop_front(); n_total++;
            if (aa.ev !== ea.ev || aa.sy !== ea.sy || (ea.ev && aa.code !== ea.code))
                $display("FAIL short_green sample %0d got ev=%b code=%0d sync=%b want ev=%b code=%0d sync=%b",
                         ea.idx, aa.ev, aa.code, aa.sy, ea.ev, ea.code, ea.sy);
            else n_pass++;
        end
    endtask

    task automatic test_long_amber();
        put(1, 0, 0, 1'b0, 3'd0, 1'b1);
        run_ok(1, 0, 0, R - 1);
        run_ok(0, 0, 1, V);
        run_ok(0, 1, 0, A);
        put(0, 1, 0, 1'b1, 3'd4, 1'b0);
        put(0, 0, 0, 1'b0, 3'd0, 1'b0);
        while (act_q.size() > 0) begin
            ea = exp_q.pop_front(); aa = act_q.pop_front(); n_total++;
            if (aa.ev !== ea.ev || aa.sy !== ea.sy || (ea.ev && aa.code !== ea.code))
                $display("FAIL long_amber sample %0d got ev=%b code=%0d sync=%b want ev=%b code=%0d sync=%b",
                         ea.idx, aa.ev, aa.code, aa.sy, ea.ev, ea.code, ea.sy);
            else n_pass++;
        end
    endtask

    task automatic test_illegal();
        put(1, 0, 0, 1'b0, 3'd0, 1'b1);
        run_ok(1, 0, 0, 4);
        put(1, 0, 1, 1'b1, 3'd1, 1'b0);
        n_total++;
        if (fase !== 2'd3) $display("FAIL illegal_fase got=%0d want=3", fase); else n_pass++;
        put(0, 0, 0, 1'b0, 3'd0, 1'b0);
        while (act_q.size() > 0) begin
            ea = exp_q.pop_front(); aa = act_q.pop_front(); n_total++;
            if (aa.ev !== ea.ev || aa.sy !== ea.sy || (ea.ev && aa.code !== ea.code))
                $display("FAIL illegal sample %0d got ev=%b code=%0d sync=%b want ev=%b code=%0d sync=%b",
                         ea.idx, aa.ev, aa.code, aa.sy, ea.ev, ea.code, ea.sy);
            else n_pass++;
        end
    endtask

    task automatic test_order();
        put(1, 0, 0, 1'b0, 3'd0, 1'b1);
        run_ok(1, 0, 0, R - 1);
        put(0, 1, 0, 1'b1, 3'd2, 1'b0);
        put(1, 0, 0, 1'b0, 3'd0, 1'b1);
        run_ok(1, 0, 0, R - 1);
        run_ok(0, 0, 1, V);
        run_ok(0, 1, 0, A);
        run_ok(1, 0, 0, 2);
        n_total++;
        if (ciclos !== 16'd4) $display("FAIL order_ciclos got=%0d want=4", ciclos); else n_pass++;
        while (act_q.size() > 0) begin
            ea = exp_q.pop_front(); aa = act_q.pop_front(); n_total++;
            if (aa.ev !== ea.ev || aa.sy !== ea.sy || (ea.ev && aa.code !== ea.code))
                $display("FAIL order sample %0d got ev=%b code=%0d sync=%b want ev=%b code=%0d sync=%b",
                         ea.idx, aa.ev, aa.code, aa.sy, ea.ev, ea.code, ea.sy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        run_ok(1, 0, 0, R - 2);
        run_ok(0, 0, 1, 5);
        n_total++;
        if (fase !== 2'd1) $display("FAIL mid_fase got=%0d want=1", fase); else n_pass++;
        while (act_q.size() > 0) begin
            ea = exp_q.pop_front(); aa = act_q.pop_front(); n_total++;
            if (aa.ev !== ea.ev || aa.sy !== ea.sy || (ea.ev && aa.code !== ea.code))
                $display("FAIL mid_pre sample %0d got ev=%b code=%0d sync=%b want ev=%b code=%0d sync=%b",
                         ea.idx, aa.ev, aa.code, aa.sy, ea.ev, ea.code, ea.sy);
            else n_pass++;
        end
        test_reset();
        put(0, 0, 1, 1'b0, 3'd0, 1'b0);
        put(1, 0, 0, 1'b0, 3'd0, 1'b1);
        put(1, 0, 0, 1'b0, 3'd0, 1'b1);
        while (act_q.size() > 0) begin
            ea = exp_q.pop_front(); aa = act_q.pop_front(); n_total++;
            if (aa.ev !== ea.ev || aa.sy !== ea.sy || (ea.ev && aa.code !== ea.code))
                $display("FAIL mid_relock sample %0d got ev=%b code=%0d sync=%b want ev=%b code=%0d sync=%b",
                         ea.idx, aa.ev, aa.code, aa.sy, ea.ev, ea.code, ea.sy);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_green();
        test_long_amber();
        test_illegal();
        test_order();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
